// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a fetch FSM (IDLE/WAIT/RESP), programmable wait states and a program-load write port.
// Define IMEM_FAULT_EN to flag misaligned or out-of-range fetches; otherwise the word index wraps modulo DEPTH.
module instr_mem_ctrl #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_iaddr,
  input  logic        i_imem_rdy,
  output logic        o_imem_vld,
  output logic [31:0] o_instr,
  output logic        o_fault,
  input  logic        i_flush,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        fault_q;
  logic [31:0] mem [DEPTH];

  logic [31:0] rd_addr;
  logic        rd_fault;
  logic [31:0] rd_data;

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic word_in_range(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE_ADDR) >> 2;
    return idx < 32'(DEPTH);
  endfunction

  // With no wait states the read happens on the accept edge itself, so use the live address.
  assign rd_addr = (state == WAIT) ? addr_q : i_iaddr;

`ifdef IMEM_FAULT_EN
  assign rd_fault = (rd_addr[1:0] != 2'b00) || !word_in_range(rd_addr);
`else
  assign rd_fault = 1'b0;
`endif

  assign rd_data = rd_fault ? NOP : mem[word_idx(rd_addr)];
  assign o_fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      o_imem_vld <= 1'b0;
      o_instr    <= NOP;
      fault_q    <= 1'b0;
    end else if (i_flush) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      o_imem_vld <= 1'b0;
      o_instr    <= NOP;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          // In RESP a ready edge both consumes the held word and accepts the next request.
          if (i_imem_rdy) begin
            addr_q <= i_iaddr;
            if (WAIT_STATES == 0) begin
              state      <= RESP;
              o_imem_vld <= 1'b1;
              o_instr    <= rd_data;
              fault_q    <= rd_fault;
            end else begin
              state      <= WAIT;
              cnt        <= WS_LOAD;
              o_imem_vld <= 1'b0;
              o_instr    <= NOP;
              fault_q    <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            o_imem_vld <= 1'b1;
            o_instr    <= rd_data;
            fault_q    <= rd_fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a same-edge read above sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (i_wr_en && word_in_range(i_wr_addr))
      mem[word_idx(i_wr_addr)] <= i_wr_data;
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: one instance with two wait states, one with none, sharing inputs.
module tb_instr_mem_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W0   = 32'h0010_0093;
  localparam logic [31:0] W1   = 32'h0020_0113;
  localparam logic [31:0] W2   = 32'h0030_0193;
  localparam logic [31:0] W3   = 32'h0040_0213;
  localparam logic [31:0] WNEW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iaddr;
  logic        rdy;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        vld2, fault2, vld0, fault0;
  logic [31:0] instr2, instr0;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [4];

  always #5 clk = ~clk;

  instr_mem_ctrl #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_iaddr(iaddr), .i_imem_rdy(rdy),
    .o_imem_vld(vld2), .o_instr(instr2), .o_fault(fault2), .i_flush(flush),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  instr_mem_ctrl #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_iaddr(iaddr), .i_imem_rdy(rdy),
    .o_imem_vld(vld0), .o_instr(instr0), .o_fault(fault0), .i_flush(flush),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    rdy   = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; iaddr = 32'd0; rdy = 1'b0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;

    repeat (2) tick();
    chk("rst_vld", {31'd0, vld2}, 32'd0);
    chk("rst_instr", instr2, NOP);
    chk("rst_fault", {31'd0, fault2}, 32'd0);
    chk("rst_instr0", instr0, NOP);
    rst_n = 1'b1;
    tick();

    // Program load
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 32'(4 * i); wr_data = words[i];
      tick();
    end
    wr_en = 1'b0;
    chk("idle_vld", {31'd0, vld2}, 32'd0);

    // Two-wait-state latency: accept edge plus two more
    rdy = 1'b1; iaddr = 32'h0;
    tick();
    rdy = 1'b0;
    chk("lat_e0_vld", {31'd0, vld2}, 32'd0);
    chk("lat_e0_instr", instr2, NOP);
    tick();
    chk("lat_e1_vld", {31'd0, vld2}, 32'd0);
    tick();
    chk("lat_e2_vld", {31'd0, vld2}, 32'd1);
    chk("lat_e2_instr", instr2, W0);

    // Backpressure hold
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_vld", {31'd0, vld2}, 32'd1);
      chk("hold_instr", instr2, W0);
    end
    rdy = 1'b1; iaddr = 32'h4;
    tick();
    rdy = 1'b0;
    chk("consume_vld", {31'd0, vld2}, 32'd0);
    tick();
    chk("b2b2_e1_vld", {31'd0, vld2}, 32'd0);
    tick();
    chk("b2b2_vld", {31'd0, vld2}, 32'd1);
    chk("b2b2_instr", instr2, W1);
    do_flush();
    chk("flush_vld", {31'd0, vld2}, 32'd0);
    chk("flush_instr", instr2, NOP);
    chk("flush_vld0", {31'd0, vld0}, 32'd0);

    // Zero-wait back-to-back
    rdy = 1'b1; iaddr = 32'h0;
    tick();
    chk("b2b0_w0_vld", {31'd0, vld0}, 32'd1);
    chk("b2b0_w0", instr0, W0);
    iaddr = 32'h4;
    tick();
    chk("b2b0_w1_vld", {31'd0, vld0}, 32'd1);
    chk("b2b0_w1", instr0, W1);
    iaddr = 32'h8;
    tick();
    rdy = 1'b0;
    chk("b2b0_w2_vld", {31'd0, vld0}, 32'd1);
    chk("b2b0_w2", instr0, W2);
    do_flush();

    // Flush during WAIT, then a full-latency request
    rdy = 1'b1; iaddr = 32'hC;
    tick();
    rdy = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flushwait_vld", {31'd0, vld2}, 32'd0);
      tick();
    end
    rdy = 1'b1; iaddr = 32'h8;
    tick();
    rdy = 1'b0;
    chk("post_flush_e0", {31'd0, vld2}, 32'd0);
    tick();
    chk("post_flush_e1", {31'd0, vld2}, 32'd0);
    tick();
    chk("post_flush_vld", {31'd0, vld2}, 32'd1);
    chk("post_flush_instr", instr2, W2);
    do_flush();

    // Misaligned and out-of-range fetches
    rdy = 1'b1; iaddr = 32'h2;
    tick();
    rdy = 1'b0;
    chk("mis_vld", {31'd0, vld0}, 32'd1);
`ifdef IMEM_FAULT_EN
    chk("mis_instr", instr0, NOP);
    chk("mis_fault", {31'd0, fault0}, 32'd1);
`else
    chk("mis_instr", instr0, W0);
    chk("mis_fault", {31'd0, fault0}, 32'd0);
`endif
    rdy = 1'b1; iaddr = 32'd64;
    tick();
    rdy = 1'b0;
    chk("oor_vld", {31'd0, vld0}, 32'd1);
`ifdef IMEM_FAULT_EN
    chk("oor_instr", instr0, NOP);
    chk("oor_fault", {31'd0, fault0}, 32'd1);
`else
    chk("oor_instr", instr0, W0);
    chk("oor_fault", {31'd0, fault0}, 32'd0);
`endif
    do_flush();

    // Write coincident with the response read returns old data
    rdy = 1'b1; iaddr = 32'h4;
    tick();
    rdy = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = WNEW;
    tick();
    wr_en = 1'b0;
    chk("rbw_vld", {31'd0, vld2}, 32'd1);
    chk("rbw_instr", instr2, W1);
    tick();
    chk("rbw_hold", instr2, W1);

    // Asynchronous reset while in RESP
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, vld2}, 32'd0);
    chk("arst_instr", instr2, NOP);
    chk("arst_vld0", {31'd0, vld0}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after1", {31'd0, vld2}, 32'd0);
    tick();
    chk("arst_after2", {31'd0, vld2}, 32'd0);
    chk("arst_after2_0", {31'd0, vld0}, 32'd0);

    // New request sees the written word
    rdy = 1'b1; iaddr = 32'h4;
    tick();
    rdy = 1'b0;
    chk("new_w1_0", instr0, WNEW);
    tick();
    tick();
    chk("new_w1_vld", {31'd0, vld2}, 32'd1);
    chk("new_w1", instr2, WNEW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
